dzcpu_oam_dma: RTL and testbench
================================

// Module: dzcpu_oam_dma
// PURPOSE
//  Bus stage between dzcpu memory port and system memory. Owns on-die HRAM (FF80-FFFE) and the
//  OAM DMA register (FF46). Forwards CPU accesses to the memory bus when idle.
//  On a CPU write to FF46 it takes the bus and copies DMA_LEN bytes from {src,8'h00} to OAM_BASE.
//  During a transfer the CPU is restricted to HRAM.
// PARAMETERS
//  DMA_REG_ADDR  16'hFF46  CPU address of DMA source register
//  OAM_BASE      16'hFE00  destination base address
//  DMA_LEN       160       bytes per transfer (1..256)
//  HRAM_LO       16'hFF80  first HRAM address
//  HRAM_HI       16'hFFFE  last HRAM address (inclusive)
// PORTS
//  iClock      in   1   clock, all state on rising edge
//  iReset_n    in   1   reset, asynchronous, active-low
//  iCpuAddr    in   16  CPU address (dzcpu oMCUAddr)
//  iCpuData    in   8   CPU write data (dzcpu oMCUData)
//  iCpuWe      in   1   CPU write enable (dzcpu oMCUwe)
//  oCpuData    out  8   read data to CPU (dzcpu iMCUData), combinational
//  oMemAddr    out  16  memory bus address
//  oMemData    out  8   memory bus write data
//  oMemWe      out  1   memory bus write enable
//  iMemData    in   8   memory bus read data, valid in same cycle as oMemAddr
//  oDmaActive  out  1   high while the DMA owns the bus (START/READ/WRITE)
// BEHAVIOUR
//  Registers: rSrc[7:0], rIdx[7:0], rLatch[7:0], rState{IDLE,START,READ,WRITE}, HRAM 127x8.
//  Reset (iReset_n=0, async): rState=IDLE, rSrc=0, rIdx=0, rLatch=0, oDmaActive=0, oMemWe=0.
//   HRAM contents are not reset.
//  CPU decode (every cycle, any state):
//  - HRAM hit (HRAM_LO..HRAM_HI): oCpuData=hram[addr-HRAM_LO]; iCpuWe writes HRAM on edge.
//    Never forwarded.
//  - DMA_REG_ADDR: oCpuData=rSrc; iCpuWe latches rSrc=iCpuData and triggers. Never forwarded.
//  - Else, IDLE: pass-through. oMemAddr=iCpuAddr, oMemData=iCpuData, oMemWe=iCpuWe,
//    oCpuData=iMemData.
//  - Else, DMA active: reads return 8'hFF; writes dropped.
//  Trigger: rising edge with iCpuWe=1 and iCpuAddr=DMA_REG_ADDR -> rState=START, rIdx=0.
//   This applies in any state: a mid-transfer trigger restarts from idx 0 with the new rSrc.
//  FSM, one state per cycle:
//  - IDLE: oDmaActive=0.
//  - START: 1 dead cycle. oMemAddr={rSrc,8'h00}, oMemWe=0. Next state READ.
//  - READ: oMemAddr={rSrc,rIdx}, oMemWe=0, rLatch<=iMemData. Next state WRITE.
//  - WRITE: oMemAddr=OAM_BASE+rIdx, oMemData=rLatch, oMemWe=1.
//    If rIdx==DMA_LEN-1: next state IDLE. Else rIdx<=rIdx+1, next state READ.
//  Timing: transfer occupies exactly 1+2*DMA_LEN cycles (321 at default).
//   oDmaActive rises the cycle after the trigger edge and falls the cycle after the last WRITE.
//  Arithmetic: source address = {rSrc,rIdx}, no carry into rSrc.
//   Destination = OAM_BASE+rIdx, 16-bit, wraps mod 2^16. rSrc values are used unmodified.
//  Precedence: a trigger on the same edge as a WRITE is handled as follows.
//   The WRITE bus cycle still completes.
//   The trigger overrides the next state (START) and rIdx (0).
//  Bus outputs are driven only by the FSM when oDmaActive=1. They are never driven by the CPU.
// TESTING
//  - Pass-through: IDLE, CPU read C123 with iMemData=5A -> oMemAddr=C123, oCpuData=5A.
//    CPU write -> oMemWe=1.
//  - Full DMA: mem C000+i=i, CPU writes C0 to FF46.
//    Expect oDmaActive for 321 cycles, 160 writes FE00+i=i, first write on 3rd cycle after the trigger edge.
//    FF46 reads back C0.
//  - HRAM during DMA: CPU writes 77 to FF90 mid-transfer, reads back 77.
//    CPU read of C000 returns FF and causes no oMemWe glitch.
//  - Restart: second FF46 write (D0) at idx 50.
//    Expect START, then copy from D000 at idx 0, total active 1+2*160 cycles after the 2nd trigger.
//  - Reset mid-DMA: drop iReset_n asynchronously at idx 80.
//    oDmaActive=0, oMemWe=0 immediately, rSrc=00. Pass-through resumes after release.

Source files
------------

// File: rtl/dzcpu_oam_dma.sv
// rtl/dzcpu_oam_dma.sv - dzcpu bus stage with on-die HRAM and OAM DMA engine
//
// Sits between the dzcpu memory port and the system memory bus. CPU accesses
// to HRAM and the DMA source register are served locally; everything else is
// passed through while the DMA engine is idle. A write to the DMA register
// starts a copy of DMA_LEN bytes from page {src,00} to OAM_BASE, during which
// the CPU only sees HRAM and the DMA register.
//
// Ports:
//   iClock      in   1   clock, all state on rising edge
//   iReset_n    in   1   asynchronous active-low reset
//   iCpuAddr    in   16  CPU address
//   iCpuData    in   8   CPU write data
//   iCpuWe      in   1   CPU write enable
//   oCpuData    out  8   read data to CPU (combinational)
//   oMemAddr    out  16  memory bus address
//   oMemData    out  8   memory bus write data
//   oMemWe      out  1   memory bus write enable
//   iMemData    in   8   memory bus read data, valid in the same cycle
//   oDmaActive  out  1   DMA owns the bus

module dzcpu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemWe,
    input  logic [7:0]  iMemData,
    output logic        oDmaActive
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam int         HRAM_SIZE = int'(HRAM_HI) - int'(HRAM_LO) + 1;
    localparam int         HRAM_AW   = $clog2(HRAM_SIZE);
    localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);

    logic [1:0]         rState;
    logic [7:0]         rSrc;
    logic [7:0]         rIdx;
    logic [7:0]         rLatch;
    logic [7:0]         hram [0:HRAM_SIZE-1];

    logic               hramHit;
    logic               regHit;
    logic               trigger;
    logic [HRAM_AW-1:0] hramIdx;

    assign hramHit    = (iCpuAddr >= HRAM_LO) && (iCpuAddr <= HRAM_HI);
    assign regHit     = (iCpuAddr == DMA_REG_ADDR);
    assign trigger    = regHit && iCpuWe;
    assign hramIdx    = HRAM_AW'(iCpuAddr - HRAM_LO);
    assign oDmaActive = (rState != IDLE);

    // HRAM keeps its contents across reset, so it has no reset branch.
    always_ff @(posedge iClock) begin
        if (hramHit && iCpuWe) begin
            hram[hramIdx] <= iCpuData;
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            rState <= IDLE;
            rSrc   <= 8'h00;
            rIdx   <= 8'h00;
            rLatch <= 8'h00;
        end else begin
            if (rState == READ) begin
                rLatch <= iMemData;
            end
            // A trigger wins over the sequencer in every state, so a
            // mid-transfer write restarts from index 0 with the new page.
            // The bus cycle of the current state is still driven below.
            if (trigger) begin
                rSrc   <= iCpuData;
                rIdx   <= 8'h00;
                rState <= START;
            end else begin
                case (rState)
                    START:   rState <= READ;
                    READ:    rState <= WRITE;
                    WRITE: begin
                        if (rIdx == LAST_IDX) begin
                            rState <= IDLE;
                        end else begin
                            rIdx   <= rIdx + 8'd1;
                            rState <= READ;
                        end
                    end
                    default: rState <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        oCpuData = iMemData;
        oMemAddr = 16'h0000;
        oMemData = 8'h00;
        oMemWe   = 1'b0;

        if (hramHit) begin
            oCpuData = hram[hramIdx];
        end else if (regHit) begin
            oCpuData = rSrc;
        end else if (oDmaActive) begin
            oCpuData = 8'hFF;
        end

        if (oDmaActive) begin
            case (rState)
                START:   oMemAddr = {rSrc, 8'h00};
                READ:    oMemAddr = {rSrc, rIdx};
                WRITE: begin
                    // Destination wraps modulo 2^16; source never carries into rSrc.
                    oMemAddr = OAM_BASE + {8'h00, rIdx};
                    oMemData = rLatch;
                    oMemWe   = 1'b1;
                end
                default: oMemAddr = 16'h0000;
            endcase
        end else if (!hramHit && !regHit) begin
            oMemAddr = iCpuAddr;
            oMemData = iCpuData;
            // Keep the bus quiet while reset is asserted.
            oMemWe   = iCpuWe && iReset_n;
        end
    end

endmodule

// File: tb/tb_dzcpu_oam_dma.sv
// tb/tb_dzcpu_oam_dma.sv - self-checking bench for dzcpu_oam_dma

module tb_dzcpu_oam_dma;

    localparam int LEN = 160;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic [15:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic        iCpuWe;
    logic [7:0]  oCpuData;
    logic [15:0] oMemAddr;
    logic [7:0]  oMemData;
    logic        oMemWe;
    logic [7:0]  iMemData;
    logic        oDmaActive;

    dzcpu_oam_dma dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iCpuAddr   (iCpuAddr),
        .iCpuData   (iCpuData),
        .iCpuWe     (iCpuWe),
        .oCpuData   (oCpuData),
        .oMemAddr   (oMemAddr),
        .oMemData   (oMemData),
        .oMemWe     (oMemWe),
        .iMemData   (iMemData),
        .oDmaActive (oDmaActive)
    );

    always #5 iClock = ~iClock;

    // Read-only backing memory; DUT writes are captured in queues instead.
    logic [7:0] srcMem [0:65535];
    logic       ovEn;
    logic [7:0] ovVal;
    always_comb iMemData = ovEn ? ovVal : srcMem[oMemAddr];

    int          nCmp = 0;
    int          nBad = 0;
    int          actCnt;
    int          firstWr;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  hm [0:126];
    bit          hv [0:126];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic [7:0]  mv;
        bit          chkCpu;
        logic [7:0]  eCpu;
        bit          fwd;
        logic        eWe;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic half();
        @(negedge iClock);
        if (oDmaActive) actCnt++;
        if (oDmaActive && oMemWe) begin
            if (firstWr < 0) firstWr = actCnt;
            wa.push_back(oMemAddr);
            wd.push_back(oMemData);
        end
    endtask

    task automatic edge_();
        @(posedge iClock);
        #1;
    endtask

    task automatic cyc();
        half();
        edge_();
    endtask

    task automatic trig(input logic [7:0] v);
        iCpuAddr = 16'hFF46; iCpuData = v; iCpuWe = 1'b1;
        cyc();
        iCpuWe = 1'b0; iCpuAddr = 16'hC000; iCpuData = 8'h00;
        actCnt = 0; firstWr = -1; wa.delete(); wd.delete();
    endtask

    task automatic waitIdle(input string nm);
        int n = 0;
        bit done = 0;
        while (n < 1000 && !done) begin
            half();
            if (!oDmaActive) done = 1;
            edge_();
            n++;
        end
        if (!done) chk({nm, " idle timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitWrites(input int cnt);
        int n = 0;
        while (wa.size() < cnt && n < 1000) begin
            cyc();
            n++;
        end
        if (wa.size() < cnt) chk("write wait timeout", wa.size(), cnt);
    endtask

    task automatic checkDma(input string nm, input logic [7:0] page);
        int bad = 0;
        chk({nm, " active cycles"}, actCnt, 1 + 2 * LEN);
        chk({nm, " first write cycle"}, firstWr, 3);
        chk({nm, " write count"}, wa.size(), LEN);
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 16'hFE00 + 16'(i) || wd[i] !== srcMem[{page, 8'(i)}]) bad++;
        end
        chk({nm, " copy errors"}, bad, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) srcMem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) srcMem[16'hC000 + i] = 8'(i);
        for (int i = 0; i < 127; i++) hv[i] = 0;
        ovEn = 1'b0; ovVal = 8'h00;
        actCnt = 0; firstWr = -1;

        // Reset state
        iCpuAddr = 16'hFF46; iCpuData = 8'h00; iCpuWe = 1'b0;
        #12;
        chk("reset dma active", oDmaActive, 1'b0);
        chk("reset mem we", oMemWe, 1'b0);
        chk("reset src readback", oCpuData, 8'h00);
        @(negedge iClock);
        iReset_n = 1'b1;
        edge_();

        // Decode table: pass-through, HRAM edges, DMA register
        tv[0] = '{16'hC123, 8'h00, 1'b0, 8'h5A, 1, 8'h5A, 1, 1'b0};
        tv[1] = '{16'hC123, 8'h33, 1'b1, 8'h00, 1, 8'h00, 1, 1'b1};
        tv[2] = '{16'hFF80, 8'h11, 1'b1, 8'h00, 0, 8'h00, 0, 1'b0};
        tv[3] = '{16'hFF80, 8'h00, 1'b0, 8'hAA, 1, 8'h11, 0, 1'b0};
        tv[4] = '{16'hFFFE, 8'h22, 1'b1, 8'h00, 0, 8'h00, 0, 1'b0};
        tv[5] = '{16'hFFFE, 8'h00, 1'b0, 8'hAA, 1, 8'h22, 0, 1'b0};
        tv[6] = '{16'hFF7F, 8'h00, 1'b0, 8'h9C, 1, 8'h9C, 1, 1'b0};
        tv[7] = '{16'hFFFF, 8'h44, 1'b1, 8'h3D, 1, 8'h3D, 1, 1'b1};
        tv[8] = '{16'hFF46, 8'h00, 1'b0, 8'hAA, 1, 8'h00, 0, 1'b0};
        tv[9] = '{16'h8000, 8'h00, 1'b0, 8'hE7, 1, 8'hE7, 1, 1'b0};
        ovEn = 1'b1;
        foreach (tv[i]) begin
            iCpuAddr = tv[i].addr; iCpuData = tv[i].data; iCpuWe = tv[i].we; ovVal = tv[i].mv;
            half();
            if (tv[i].chkCpu) chk($sformatf("vec%0d cpu data", i), oCpuData, tv[i].eCpu);
            chk($sformatf("vec%0d mem we", i), oMemWe, tv[i].eWe);
            chk($sformatf("vec%0d dma active", i), oDmaActive, 1'b0);
            if (tv[i].fwd) begin
                chk($sformatf("vec%0d mem addr", i), oMemAddr, tv[i].addr);
                if (tv[i].we) chk($sformatf("vec%0d mem data", i), oMemData, tv[i].data);
            end
            edge_();
        end
        iCpuWe = 1'b0;
        ovEn = 1'b0;

        // Full DMA from C0 with HRAM access and blocked reads in the middle
        trig(8'hC0);
        half();
        chk("dma blocked read", oCpuData, 8'hFF);
        chk("dma started", oDmaActive, 1'b1);
        edge_();
        repeat (20) cyc();
        iCpuAddr = 16'hFF90; iCpuData = 8'h77; iCpuWe = 1'b1;
        cyc();
        iCpuWe = 1'b0;
        half();
        chk("hram during dma", oCpuData, 8'h77);
        edge_();
        iCpuAddr = 16'hFF46;
        half();
        chk("src readback during dma", oCpuData, 8'hC0);
        edge_();
        iCpuAddr = 16'hC000;
        waitIdle("full");
        checkDma("full", 8'hC0);

        // Restart with a new page at index 50
        trig(8'hC0);
        waitWrites(50);
        trig(8'hD0);
        waitIdle("restart");
        checkDma("restart", 8'hD0);
        iCpuAddr = 16'hFF46;
        half();
        chk("src after restart", oCpuData, 8'hD0);
        edge_();

        // Randomized transfers and CPU traffic against the reference model
        for (int r = 0; r < 4; r++) begin
            logic [7:0] page;
            page = 8'($urandom_range(0, 253));
            trig(page);
            waitIdle("random");
            checkDma($sformatf("random%0d", r), page);
            for (int k = 0; k < 30; k++) begin
                int kind;
                int idx;
                logic [15:0] a;
                kind = $urandom_range(0, 2);
                iCpuData = 8'($urandom);
                iCpuWe = 1'($urandom);
                if (kind == 0) begin
                    idx = $urandom_range(0, 126);
                    iCpuAddr = 16'hFF80 + 16'(idx);
                    half();
                    chk("rand hram we", oMemWe, 1'b0);
                    if (!iCpuWe && hv[idx]) chk("rand hram read", oCpuData, hm[idx]);
                    if (iCpuWe) begin hm[idx] = iCpuData; hv[idx] = 1; end
                end else if (kind == 1) begin
                    a = 16'($urandom_range(0, 16'hFF7F));
                    if (a == 16'hFF46) a = 16'hFF45;
                    iCpuAddr = a;
                    half();
                    chk("rand fwd addr", oMemAddr, a);
                    chk("rand fwd we", oMemWe, iCpuWe);
                    if (iCpuWe) chk("rand fwd data", oMemData, iCpuData);
                    else chk("rand fwd read", oCpuData, srcMem[a]);
                end else begin
                    iCpuWe = 1'b0;
                    iCpuAddr = 16'hFF46;
                    half();
                    chk("rand src readback", oCpuData, page);
                    chk("rand reg we", oMemWe, 1'b0);
                end
                edge_();
            end
            iCpuWe = 1'b0;
        end

        // Asynchronous reset in the middle of a transfer
        trig(8'hC0);
        waitWrites(80);
        iCpuAddr = 16'hFF46; iCpuWe = 1'b0;
        #2;
        iReset_n = 1'b0;
        #1;
        chk("async reset dma active", oDmaActive, 1'b0);
        chk("async reset mem we", oMemWe, 1'b0);
        chk("async reset src", oCpuData, 8'h00);
        @(negedge iClock);
        iReset_n = 1'b1;
        edge_();
        iCpuAddr = 16'hC123;
        half();
        chk("post reset fwd addr", oMemAddr, 16'hC123);
        chk("post reset fwd read", oCpuData, srcMem[16'hC123]);
        chk("post reset idle", oDmaActive, 1'b0);
        edge_();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
